// File: rtl/multi_track_sequencer.sv
// Multi-track step sequencer playback core: BPM step clock, loop control,
// per-channel square tones mixed with saturation into one audio sample.

module mts_tone #(
  parameter int HP_W = 20
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            retrig_i,
  input  logic [HP_W-1:0] hp_i,
  output logic            ph_o
);
  logic [HP_W-1:0] cnt_q, hp_q;
  logic            ph_q;

  // ph_q = 0 is the positive half of the square wave
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      hp_q  <= '0;
      ph_q  <= 1'b0;
    end else begin
      hp_q <= hp_i;
      if (clr_i || retrig_i) begin
        cnt_q <= '0;
        ph_q  <= 1'b0;
      end else if (hp_i != hp_q || hp_q == '0) begin
        cnt_q <= '0;
      end else if (cnt_q == hp_q - HP_W'(1)) begin
        cnt_q <= '0;
        ph_q  <= ~ph_q;
      end else begin
        cnt_q <= cnt_q + HP_W'(1);
      end
    end
  end

  assign ph_o = ph_q;
endmodule

module multi_track_sequencer #(
  parameter int          CHANNELS = 4,
  parameter int          STEPS    = 16,
  parameter int          SAMPLE_W = 16,
  parameter int          AMP      = 8191,
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int          HP_W     = 20
) (
  input  logic                         CLOCK_50,
  input  logic                         nReset,
  input  logic                         nStart,
  input  logic                         nStop,
  input  logic [9:0]                   BPM,
  input  logic [6:0]                   Loops,
  input  logic [CHANNELS*STEPS-1:0]    pattern,
  input  logic [CHANNELS*HP_W-1:0]     half_period,
  input  logic                         audio_out_allowed,
  output logic signed [SAMPLE_W-1:0]   sample_out,
  output logic                         write_audio_out,
  output logic                         step_pulse,
  output logic [$clog2(STEPS)-1:0]     step_index,
  output logic [6:0]                   loop_count,
  output logic                         playing,
  output logic                         done
);
  localparam int SI_W  = $clog2(STEPS);
  localparam int MIX_W = SAMPLE_W + $clog2(CHANNELS) + 1;
  localparam logic [32:0] T = 33'(64'(CLK_HZ) * 64'd60);
  localparam logic signed [MIX_W-1:0] AMP_M = MIX_W'(AMP);
  localparam logic signed [MIX_W-1:0] S_MAX = MIX_W'((64'd1 << (SAMPLE_W-1)) - 64'd1);
  localparam logic signed [MIX_W-1:0] S_MIN = ~S_MAX;

  typedef enum logic {IDLE, RUN} state_e;

  state_e                      state_q;
  logic                        nstart_q, pulse_q, done_q, wr_q;
  logic [31:0]                 acc_q;
  logic [6:0]                  loops_q, loop_q;
  logic [SI_W-1:0]             step_q;
  logic signed [SAMPLE_W-1:0]  sample_q, sample_d;

  logic                        start, hit, wrap, fin;
  logic [32:0]                 sum;
  logic [SI_W-1:0]             step_nxt;
  logic [6:0]                  loop_nxt;
  logic [CHANNELS-1:0]         ph, act, retrig;
  logic signed [MIX_W-1:0]     mix;

  assign start    = nstart_q & ~nStart;
  assign sum      = {1'b0, acc_q} + {23'd0, BPM};
  assign hit      = (state_q == RUN) && (sum >= T);
  assign wrap     = (step_q == SI_W'(STEPS-1));
  assign step_nxt = wrap ? '0 : step_q + SI_W'(1);
  assign loop_nxt = (loop_q == 7'd127) ? loop_q : loop_q + 7'd1;
  assign fin      = hit && wrap && (loops_q != '0) && (loop_nxt == loops_q);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [STEPS-1:0] row;
    logic [HP_W-1:0]  hp;
    assign row       = pattern[c*STEPS +: STEPS];
    assign hp        = half_period[c*HP_W +: HP_W];
    assign act[c]    = (state_q == RUN) && row[step_q] && (hp != '0);
    // a channel sounding on the step being entered starts from a fresh + half
    assign retrig[c] = hit && nStop && !start && !fin && row[step_nxt];

    mts_tone #(.HP_W(HP_W)) u_tone (
      .clk_i   (CLOCK_50),
      .rst_ni  (nReset),
      .clr_i   (start && nStop),
      .retrig_i(retrig[c]),
      .hp_i    (hp),
      .ph_o    (ph[c])
    );
  end

  always_comb begin
    mix = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (act[c]) mix = ph[c] ? mix - AMP_M : mix + AMP_M;
    if (mix > S_MAX)      sample_d = S_MAX[SAMPLE_W-1:0];
    else if (mix < S_MIN) sample_d = S_MIN[SAMPLE_W-1:0];
    else                  sample_d = mix[SAMPLE_W-1:0];
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      nstart_q <= 1'b1;
      acc_q    <= '0;
      loops_q  <= '0;
      step_q   <= '0;
      loop_q   <= '0;
      pulse_q  <= 1'b0;
      done_q   <= 1'b0;
      wr_q     <= 1'b0;
      sample_q <= '0;
    end else begin
      nstart_q <= nStart;
      wr_q     <= audio_out_allowed;
      pulse_q  <= 1'b0;
      done_q   <= 1'b0;
      if (!nStop) begin
        state_q  <= IDLE;
        step_q   <= '0;
        sample_q <= '0;
      end else begin
        // hold the sample while the codec FIFO is refusing writes
        if (audio_out_allowed) sample_q <= sample_d;
        if (start) begin
          state_q <= RUN;
          step_q  <= '0;
          loop_q  <= '0;
          acc_q   <= '0;
          loops_q <= Loops;
        end else if (state_q == RUN) begin
          acc_q <= hit ? 32'(sum - T) : sum[31:0];
          if (hit) begin
            pulse_q <= 1'b1;
            step_q  <= fin ? '0 : step_nxt;
            if (wrap) loop_q <= loop_nxt;
            if (fin) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
      end
    end
  end

  assign sample_out      = sample_q;
  assign write_audio_out = wr_q;
  assign step_pulse      = pulse_q;
  assign step_index      = step_q;
  assign loop_count      = loop_q;
  assign playing         = (state_q == RUN);
  assign done            = done_q;
endmodule

// File: tb/tb_multi_track_sequencer.sv
// Bench for multi_track_sequencer: table vectors, directed corner sequences and
// random stimulus, all cross-checked every cycle against a behavioural model.

module tb_multi_track_sequencer;
  localparam int CH = 3, ST = 4, SW = 16, AMP = 12000, CLKHZ = 1000, HPW = 8;
  localparam int T = 60 * CLKHZ;

  logic clk = 1'b0;
  logic nReset, nStart, nStop, allowed;
  logic [9:0] bpm;
  logic [6:0] loops;
  logic [CH*ST-1:0] pat;
  logic [CH*HPW-1:0] hp;
  logic signed [SW-1:0] sample_out;
  logic write_audio_out, step_pulse, playing, done;
  logic [1:0] step_index;
  logic [6:0] loop_count;

  int checks = 0, failures = 0;

  multi_track_sequencer #(
    .CHANNELS(CH), .STEPS(ST), .SAMPLE_W(SW), .AMP(AMP), .CLK_HZ(CLKHZ), .HP_W(HPW)
  ) dut (
    .CLOCK_50(clk), .nReset(nReset), .nStart(nStart), .nStop(nStop),
    .BPM(bpm), .Loops(loops), .pattern(pat), .half_period(hp),
    .audio_out_allowed(allowed), .sample_out(sample_out),
    .write_audio_out(write_audio_out), .step_pulse(step_pulse),
    .step_index(step_index), .loop_count(loop_count), .playing(playing), .done(done)
  );

  always #5 clk = ~clk;

  // behavioural model state: tone sign +1/-1, cycles elapsed in current half
  int m_run, m_acc, m_step, m_loop, m_loops, m_nsp, m_sample, m_wr, m_pulse, m_done;
  int m_cnt[CH], m_sgn[CH], m_hpp[CH];

  function automatic int hpc(input int c);
    return int'(hp[c*HPW +: HPW]);
  endfunction

  task automatic model_reset();
    m_run = 0; m_acc = 0; m_step = 0; m_loop = 0; m_loops = 0; m_nsp = 1;
    m_sample = 0; m_wr = 0; m_pulse = 0; m_done = 0;
    for (int c = 0; c < CH; c++) begin m_cnt[c] = 0; m_sgn[c] = 1; m_hpp[c] = 0; end
  endtask

  task automatic model_step();
    int edge_s, mix, ns, a, h;
    int rt[CH];
    edge_s = (m_nsp == 1 && nStart == 1'b0);
    m_nsp  = int'(nStart);
    mix = 0;
    for (int c = 0; c < CH; c++)
      if (m_run != 0 && pat[c*ST + m_step] && hpc(c) != 0) mix += m_sgn[c] * AMP;
    if (mix > 32767) mix = 32767;
    if (mix < -32768) mix = -32768;
    m_wr = int'(allowed); m_pulse = 0; m_done = 0;
    for (int c = 0; c < CH; c++) rt[c] = 0;
    if (!nStop) begin
      m_run = 0; m_step = 0; m_sample = 0;
    end else begin
      if (allowed) m_sample = mix;
      if (edge_s != 0) begin
        m_run = 1; m_step = 0; m_loop = 0; m_acc = 0; m_loops = int'(loops);
      end else if (m_run != 0) begin
        a = m_acc + int'(bpm);
        if (a >= T) begin
          m_acc = a - T; m_pulse = 1; ns = (m_step + 1) % ST;
          if (ns == 0 && m_loop < 127) m_loop++;
          if (ns == 0 && m_loops != 0 && m_loop == m_loops) begin
            m_done = 1; m_run = 0; m_step = 0;
          end else begin
            m_step = ns;
            for (int c = 0; c < CH; c++) rt[c] = int'(pat[c*ST + ns]);
          end
        end else m_acc = a;
      end
    end
    for (int c = 0; c < CH; c++) begin
      h = hpc(c);
      if ((nStop && edge_s != 0) || rt[c] != 0) begin m_cnt[c] = 0; m_sgn[c] = 1; end
      else if (h != m_hpp[c] || h == 0) m_cnt[c] = 0;
      else begin
        m_cnt[c]++;
        if (m_cnt[c] == h) begin m_cnt[c] = 0; m_sgn[c] = -m_sgn[c]; end
      end
      m_hpp[c] = h;
    end
  endtask

  task automatic cmp_model();
    checks++;
    if ($signed(sample_out) !== m_sample || write_audio_out !== 1'(m_wr) ||
        step_pulse !== 1'(m_pulse) || step_index !== 2'(m_step) ||
        loop_count !== 7'(m_loop) || playing !== 1'(m_run) || done !== 1'(m_done)) begin
      failures++;
      $display("FAIL model t=%0t got s=%0d w=%0b p=%0b i=%0d l=%0d r=%0b d=%0b required s=%0d w=%0d p=%0d i=%0d l=%0d r=%0d d=%0d",
               $time, sample_out, write_audio_out, step_pulse, step_index, loop_count, playing, done,
               m_sample, m_wr, m_pulse, m_step, m_loop, m_run, m_done);
    end
  endtask

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_model();
  endtask

  typedef struct {
    logic [CH*ST-1:0]  pat;
    logic [CH*HPW-1:0] hp;
    int pos;
    int neg;
  } vec_t;
  vec_t vt[7];

  initial begin
    int n, wraps, dseen, c;
    logic signed [SW-1:0] held;
    logic [3:0] aseq;

    vt[0] = '{12'h001, {8'd5, 8'd5, 8'd5}, 12000, -12000};
    vt[1] = '{12'h011, {8'd5, 8'd5, 8'd5}, 24000, -24000};
    vt[2] = '{12'h111, {8'd5, 8'd5, 8'd5}, 32767, -32768};
    vt[3] = '{12'h000, {8'd5, 8'd5, 8'd5}, 0, 0};
    vt[4] = '{12'h111, {8'd5, 8'd0, 8'd5}, 24000, -24000};
    vt[5] = '{12'h222, {8'd5, 8'd5, 8'd5}, 0, 0};
    vt[6] = '{12'h101, {8'd2, 8'd0, 8'd5}, 24000, 0};

    nReset = 1'b0; nStart = 1'b1; nStop = 1'b1; allowed = 1'b1;
    bpm = '0; loops = '0; pat = '0; hp = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_sample", sample_out, 0);
    chk("rst_write", write_audio_out, 0);
    chk("rst_playing", playing, 0);
    chk("rst_step", step_index, 0);
    nReset = 1'b1;

    // step timing, index sequence and done after Loops passes
    bpm = 10'd600; loops = 7'd2; nStart = 1'b0; tick(); nStart = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      n = 0;
      do begin tick(); n++; end while (!step_pulse && n < 300);
      chk("step_interval", n, 100);
      chk("step_idx", step_index, (k == 8) ? 0 : k % 4);
      chk("done_pulse", done, (k == 8) ? 1 : 0);
      if (k == 4) chk("loop_after_pass1", loop_count, 1);
    end
    chk("end_playing", playing, 0);
    chk("end_loops", loop_count, 2);
    repeat (5) tick();
    chk("stay_idle", playing, 0);

    // mix / saturation table
    loops = 7'd0;
    for (int i = 0; i < 7; i++) begin
      pat = vt[i].pat; hp = vt[i].hp; nStart = 1'b0; tick(); nStart = 1'b1;
      tick();
      chk("vec_pos", $signed(sample_out), vt[i].pos);
      repeat (5) tick();
      chk("vec_neg", $signed(sample_out), vt[i].neg);
      nStop = 1'b0; tick();
      chk("vec_stop_sample", sample_out, 0);
      chk("vec_stop_playing", playing, 0);
      nStop = 1'b1; tick();
    end

    // channel sounding on steps 0 and 2 only
    pat = 12'h005; hp = {8'd0, 8'd0, 8'd5}; nStart = 1'b0; tick(); nStart = 1'b1;
    repeat (110) tick();
    chk("s1_step", step_index, 1);
    chk("s1_silent", sample_out, 0);
    repeat (100) tick();
    chk("s2_step", step_index, 2);
    chk("s2_sounds", ($signed(sample_out) == 12000 || $signed(sample_out) == -12000), 1);
    repeat (100) tick();
    chk("s3_silent", sample_out, 0);
    nStop = 1'b0; tick(); nStop = 1'b1; tick();

    // write strobe handshake and sample hold
    pat = 12'h001; hp = {8'd0, 8'd0, 8'd1}; nStart = 1'b0; tick(); nStart = 1'b1;
    repeat (3) tick();
    aseq = 4'b1001; held = '0;
    for (int i = 0; i < 4; i++) begin
      allowed = aseq[3-i]; tick();
      chk("wr_delay", write_audio_out, aseq[3-i]);
      if (aseq[3-i]) held = SW'(m_sample);
      else chk("hold_sample", $signed(sample_out), held);
    end
    allowed = 1'b1;
    nStop = 1'b0; tick(); nStop = 1'b1; tick();

    // asynchronous reset mid-step
    pat = 12'hFFF; hp = {8'd3, 8'd4, 8'd5}; nStart = 1'b0; tick(); nStart = 1'b1;
    repeat (150) tick();
    nReset = 1'b0; #1;
    chk("arst_sample", sample_out, 0);
    chk("arst_playing", playing, 0);
    chk("arst_step", step_index, 0);
    chk("arst_loop", loop_count, 0);
    chk("arst_write", write_audio_out, 0);
    model_reset();
    @(posedge clk); @(negedge clk);
    nReset = 1'b1;
    repeat (20) tick();
    chk("arst_stays_idle", playing, 0);

    // infinite looping, loop counter saturation
    bpm = 10'd1023; loops = 7'd0; nStart = 1'b0; tick(); nStart = 1'b1;
    wraps = 0; dseen = 0; n = 0;
    while (wraps < 130 && n < 40000) begin
      tick(); n++;
      if (step_pulse && step_index == 2'd0) wraps++;
      if (done) dseen = 1;
    end
    chk("inf_wraps", wraps, 130);
    chk("inf_no_done", dseen, 0);
    chk("inf_loop_sat", loop_count, 127);
    chk("inf_playing", playing, 1);
    nStop = 1'b0; tick();
    chk("inf_stop_sample", sample_out, 0);
    chk("inf_stop_playing", playing, 0);
    chk("inf_stop_loop", loop_count, 127);
    nStop = 1'b1; tick();

    // random traffic against the model
    nStart = 1'b0; tick();
    for (int i = 0; i < 4000; i++) begin
      nStart = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      nStop  = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 99) == 0) bpm = 10'($urandom_range(300, 1023));
      if ($urandom_range(0, 49) == 0) pat = 12'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        c = int'($urandom_range(0, CH-1));
        hp[c*HPW +: HPW] = 8'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 19) == 0) loops = 7'($urandom_range(0, 3));
      allowed = ($urandom_range(0, 6) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
